// File: rtl/vga_layer_compositor.sv
// ---------------------------------------------------------------------------
// vga_layer_compositor
//
// Two-stage pixel compositor that stacks NUM_LAYERS RGB sources on top of a
// background fill colour. Layer 0 is the bottom layer; the highest index is
// on top. Each layer can be enabled, 50% blended with the result beneath it,
// or blinked on frame_count[BLINK_BIT]. Layer controls are written into a
// shadow set and copied to the active set only on a vsync rising edge, so a
// frame is never composited with mixed settings.
//
// Ports
//   clk_in, rst_in          pixel clock, asynchronous active-high reset
//   layer_pixel_in          NUM_LAYERS packed pixels, layer i at [i*PW +: PW]
//   layer_opaque_in         per-layer "pixel present" flags
//   hsync_in/vsync_in/blank_in  timing aligned with the pixels
//   cfg_write_in            strobe that loads the shadow configuration
//   cfg_enable_in/cfg_blend_in/cfg_blink_in/cfg_fill_in  shadow values
//   pixel_out               composited pixel, 2 cycles after input
//   hsync_out/vsync_out/blank_out  timing delayed by the same 2 cycles
//   frame_count_out         frame counter, increments on vsync rising edge
//   cfg_pending_out         shadow written but not yet applied
// ---------------------------------------------------------------------------
module vga_layer_compositor #(
   parameter int NUM_LAYERS      = 4,
   parameter int PIXEL_WIDTH     = 12,
   parameter int FRAME_CNT_WIDTH = 8,
   parameter int BLINK_BIT       = 4
) (
   input  logic                              clk_in,
   input  logic                              rst_in,
   input  logic [NUM_LAYERS*PIXEL_WIDTH-1:0] layer_pixel_in,
   input  logic [NUM_LAYERS-1:0]             layer_opaque_in,
   input  logic                              hsync_in,
   input  logic                              vsync_in,
   input  logic                              blank_in,
   input  logic                              cfg_write_in,
   input  logic [NUM_LAYERS-1:0]             cfg_enable_in,
   input  logic [NUM_LAYERS-1:0]             cfg_blend_in,
   input  logic [NUM_LAYERS-1:0]             cfg_blink_in,
   input  logic [PIXEL_WIDTH-1:0]            cfg_fill_in,
   output logic [PIXEL_WIDTH-1:0]            pixel_out,
   output logic                              hsync_out,
   output logic                              vsync_out,
   output logic                              blank_out,
   output logic [FRAME_CNT_WIDTH-1:0]        frame_count_out,
   output logic                              cfg_pending_out
);

   localparam int CW = PIXEL_WIDTH / 3;

   // Per-channel 50% mix; the CW+1 bit sum is truncated, no rounding.
   function automatic logic [PIXEL_WIDTH-1:0] avg_pix(
      input logic [PIXEL_WIDTH-1:0] a,
      input logic [PIXEL_WIDTH-1:0] b
   );
      logic [PIXEL_WIDTH-1:0] res;
      logic [CW:0]            sum;
      res = '0;
      for (int c = 0; c < 3; c++) begin
         sum = {1'b0, a[c*CW +: CW]} + {1'b0, b[c*CW +: CW]};
         res[c*CW +: CW] = sum[CW:1];
      end
      return res;
   endfunction

   // Configuration / frame control
   logic                       vsync_q;
   logic                       frame_edge;
   logic                       pending;
   logic [FRAME_CNT_WIDTH-1:0] frame_cnt;
   logic [NUM_LAYERS-1:0]      sh_enable, sh_blend, sh_blink;
   logic [PIXEL_WIDTH-1:0]     sh_fill;
   logic [NUM_LAYERS-1:0]      act_enable, act_blend, act_blink;
   logic [PIXEL_WIDTH-1:0]     act_fill;

   // vsync_q resets low, so vsync held high across reset release counts as an edge.
   assign frame_edge = vsync_in & ~vsync_q;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         vsync_q    <= 1'b0;
         pending    <= 1'b0;
         frame_cnt  <= '0;
         sh_enable  <= '1;
         sh_blend   <= '0;
         sh_blink   <= '0;
         sh_fill    <= '0;
         act_enable <= '1;
         act_blend  <= '0;
         act_blink  <= '0;
         act_fill   <= '0;
      end else begin
         vsync_q <= vsync_in;
         if (frame_edge)
            frame_cnt <= frame_cnt + FRAME_CNT_WIDTH'(1);
         if (cfg_write_in) begin
            sh_enable <= cfg_enable_in;
            sh_blend  <= cfg_blend_in;
            sh_blink  <= cfg_blink_in;
            sh_fill   <= cfg_fill_in;
         end
         // Active takes the shadow value from before any same-cycle write.
         if (frame_edge && pending) begin
            act_enable <= sh_enable;
            act_blend  <= sh_blend;
            act_blink  <= sh_blink;
            act_fill   <= sh_fill;
         end
         // A write on the edge cycle keeps pending set for the next frame.
         if (cfg_write_in)
            pending <= 1'b1;
         else if (frame_edge)
            pending <= 1'b0;
      end
   end

   // ---- Stage 1: capture pixels, timing and per-pixel configuration ----
   logic [NUM_LAYERS*PIXEL_WIDTH-1:0] pix_p1;
   logic [NUM_LAYERS-1:0]             vis_p1, blend_p1;
   logic [PIXEL_WIDTH-1:0]            fill_p1;
   logic                              hsync_p1, vsync_p1, blank_p1;
   logic [NUM_LAYERS-1:0]             vis_p0;

   assign vis_p0 = layer_opaque_in & act_enable &
                   ~(act_blink & {NUM_LAYERS{frame_cnt[BLINK_BIT]}});

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         pix_p1   <= '0;
         vis_p1   <= '0;
         blend_p1 <= '0;
         fill_p1  <= '0;
         hsync_p1 <= 1'b0;
         vsync_p1 <= 1'b0;
         blank_p1 <= 1'b0;
      end else begin
         pix_p1   <= layer_pixel_in;
         vis_p1   <= vis_p0;
         blend_p1 <= act_blend;
         fill_p1  <= act_fill;
         hsync_p1 <= hsync_in;
         vsync_p1 <= vsync_in;
         blank_p1 <= blank_in;
      end
   end

   // ---- Stage 2: bottom-to-top composite, blanking ----
   logic [PIXEL_WIDTH-1:0] acc_p1;

   always_comb begin
      acc_p1 = fill_p1;
      for (int i = 0; i < NUM_LAYERS; i++) begin
         if (vis_p1[i])
            acc_p1 = blend_p1[i] ? avg_pix(acc_p1, pix_p1[i*PIXEL_WIDTH +: PIXEL_WIDTH])
                                 : pix_p1[i*PIXEL_WIDTH +: PIXEL_WIDTH];
      end
   end

   logic [PIXEL_WIDTH-1:0] pixel_p2;
   logic                   hsync_p2, vsync_p2, blank_p2;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         pixel_p2 <= '0;
         hsync_p2 <= 1'b0;
         vsync_p2 <= 1'b0;
         blank_p2 <= 1'b0;
      end else begin
         pixel_p2 <= blank_p1 ? '0 : acc_p1;
         hsync_p2 <= hsync_p1;
         vsync_p2 <= vsync_p1;
         blank_p2 <= blank_p1;
      end
   end

   assign pixel_out       = pixel_p2;
   assign hsync_out       = hsync_p2;
   assign vsync_out       = vsync_p2;
   assign blank_out       = blank_p2;
   assign frame_count_out = frame_cnt;
   assign cfg_pending_out = pending;

endmodule

// File: tb/tb_vga_layer_compositor.sv
module tb_vga_layer_compositor;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic [47:0] layer_pixel_in = '0;
   logic [3:0]  layer_opaque_in = '0;
   logic        hsync_in = 1'b0, vsync_in = 1'b0, blank_in = 1'b0;
   logic        cfg_write_in = 1'b0;
   logic [3:0]  cfg_enable_in = '0, cfg_blend_in = '0, cfg_blink_in = '0;
   logic [11:0] cfg_fill_in = '0;
   logic [11:0] pixel_out;
   logic        hsync_out, vsync_out, blank_out;
   logic [7:0]  frame_count_out;
   logic        cfg_pending_out;

   vga_layer_compositor #(
      .NUM_LAYERS(4), .PIXEL_WIDTH(12), .FRAME_CNT_WIDTH(8), .BLINK_BIT(0)
   ) dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .layer_pixel_in(layer_pixel_in), .layer_opaque_in(layer_opaque_in),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in),
      .cfg_write_in(cfg_write_in), .cfg_enable_in(cfg_enable_in),
      .cfg_blend_in(cfg_blend_in), .cfg_blink_in(cfg_blink_in),
      .cfg_fill_in(cfg_fill_in),
      .pixel_out(pixel_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
      .blank_out(blank_out), .frame_count_out(frame_count_out),
      .cfg_pending_out(cfg_pending_out)
   );

   always #5 clk_in = ~clk_in;

   int errors = 0;
   int checks = 0;
   logic [7:0] fc_model = '0;

   typedef struct {
      string       name;
      logic [3:0]  en, blend;
      logic [11:0] fill;
      logic [3:0]  op;
      logic [11:0] p0, p1, p2, p3;
      logic        blank;
      logic [11:0] exp;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled there too.
   task automatic step();
      @(negedge clk_in);
   endtask

   task automatic set_layers(input logic [11:0] p0, p1, p2, p3, input logic [3:0] op);
      layer_pixel_in  = {p3, p2, p1, p0};
      layer_opaque_in = op;
   endtask

   task automatic cfg_write(input logic [3:0] en, bl, bk, input logic [11:0] fill);
      cfg_enable_in = en; cfg_blend_in = bl; cfg_blink_in = bk; cfg_fill_in = fill;
      cfg_write_in  = 1'b1;
      step();
      cfg_write_in  = 1'b0;
   endtask

   task automatic frame_pulse();
      vsync_in = 1'b1;
      step();
      vsync_in = 1'b0;
      fc_model++;
      step();
   endtask

   initial begin
      vecs[0] = '{"prio_l2",   4'hF, 4'h0, 12'h000, 4'b0101, 12'h111, 12'h222, 12'hF00, 12'h333, 1'b0, 12'hF00};
      vecs[1] = '{"prio_l0",   4'hF, 4'h0, 12'h000, 4'b0001, 12'h111, 12'h222, 12'hF00, 12'h333, 1'b0, 12'h111};
      vecs[2] = '{"blend_l1",  4'h3, 4'h2, 12'h000, 4'b1111, 12'h0F0, 12'hF00, 12'h123, 12'h456, 1'b0, 12'h770};
      vecs[3] = '{"blend_fill",4'h1, 4'h1, 12'h000, 4'b1111, 12'hFFF, 12'h111, 12'h222, 12'h333, 1'b0, 12'h777};
      vecs[4] = '{"none_vis",  4'hF, 4'h0, 12'h5A3, 4'b0000, 12'h111, 12'h222, 12'h333, 12'h444, 1'b0, 12'h5A3};
      vecs[5] = '{"blank",     4'hF, 4'h0, 12'h5A3, 4'b1111, 12'h111, 12'h222, 12'h333, 12'h444, 1'b1, 12'h000};
      vecs[6] = '{"blend_chain",4'hB,4'hA, 12'h000, 4'b1111, 12'hFFF, 12'h000, 12'h888, 12'h0F0, 1'b0, 12'h3B3};
      vecs[7] = '{"top_off",   4'h7, 4'h0, 12'h000, 4'b1111, 12'h00A, 12'h00B, 12'h00C, 12'h00D, 1'b0, 12'h00C};
      vecs[8] = '{"blend_trunc",4'h1,4'h1, 12'h135, 4'b0001, 12'h0F2, 12'h000, 12'h000, 12'h000, 1'b0, 12'h093};

      // Reset with random inputs: every output must stay 0.
      for (int i = 0; i < 4; i++) begin
         layer_pixel_in  = {$urandom, $urandom};
         layer_opaque_in = 4'($urandom);
         hsync_in = 1'($urandom); vsync_in = 1'($urandom); blank_in = 1'($urandom);
         cfg_write_in = 1'($urandom); cfg_enable_in = 4'($urandom);
         cfg_fill_in = 12'($urandom);
         step();
      end
      chk("rst_pixel", 32'(pixel_out), 0);
      chk("rst_hsync", 32'(hsync_out), 0);
      chk("rst_vsync", 32'(vsync_out), 0);
      chk("rst_blank", 32'(blank_out), 0);
      chk("rst_fcnt",  32'(frame_count_out), 0);
      chk("rst_pend",  32'(cfg_pending_out), 0);

      hsync_in = 0; vsync_in = 0; blank_in = 0; cfg_write_in = 0;
      set_layers(12'h123, 12'h456, 12'h789, 12'hABC, 4'hF);
      rst_in = 1'b0;
      step();
      chk("rst_lat1", 32'(pixel_out), 0);
      step();
      chk("rst_lat2_l3", 32'(pixel_out), 32'hABC);

      // Table of steady-state composites.
      foreach (vecs[k]) begin
         cfg_write(vecs[k].en, vecs[k].blend, 4'h0, vecs[k].fill);
         frame_pulse();
         set_layers(vecs[k].p0, vecs[k].p1, vecs[k].p2, vecs[k].p3, vecs[k].op);
         blank_in = vecs[k].blank;
         step(); step(); step();
         chk(vecs[k].name, 32'(pixel_out), 32'(vecs[k].exp));
         blank_in = 1'b0;
      end

      // Sync/blank pulses come out exactly 2 cycles later.
      hsync_in = 1'b1; blank_in = 1'b1;
      step();
      hsync_in = 1'b0; blank_in = 1'b0;
      chk("hs_d1", 32'(hsync_out), 0);
      step();
      chk("hs_d2", 32'(hsync_out), 1);
      chk("bl_d2", 32'(blank_out), 1);
      step();
      chk("hs_d3", 32'(hsync_out), 0);
      chk("bl_d3", 32'(blank_out), 0);
      vsync_in = 1'b1;
      step();
      vsync_in = 1'b0; fc_model++;
      chk("vs_d1", 32'(vsync_out), 0);
      chk("fcnt_edge", 32'(frame_count_out), 32'(fc_model));
      step();
      chk("vs_d2", 32'(vsync_out), 1);
      step();
      chk("vs_d3", 32'(vsync_out), 0);

      // Shadowing: disabling L2 waits for the frame edge.
      cfg_write(4'hF, 4'h0, 4'h0, 12'h000);
      frame_pulse();
      set_layers(12'h111, 12'h222, 12'hF00, 12'h333, 4'b0101);
      step(); step();
      chk("sh_before", 32'(pixel_out), 32'hF00);
      cfg_write(4'b1011, 4'h0, 4'h0, 12'h000);
      chk("sh_pend_set", 32'(cfg_pending_out), 1);
      step(); step();
      chk("sh_midframe", 32'(pixel_out), 32'hF00);
      vsync_in = 1'b1;
      step();
      vsync_in = 1'b0; fc_model++;
      chk("sh_pend_clr", 32'(cfg_pending_out), 0);
      step();
      chk("sh_edge_pix", 32'(pixel_out), 32'hF00);
      step();
      chk("sh_applied", 32'(pixel_out), 32'h111);

      // Write on the edge cycle: applies one frame later.
      cfg_enable_in = 4'hF; cfg_write_in = 1'b1; vsync_in = 1'b1;
      step();
      cfg_write_in = 1'b0; vsync_in = 1'b0; fc_model++;
      chk("same_pend", 32'(cfg_pending_out), 1);
      step(); step(); step();
      chk("same_hold", 32'(pixel_out), 32'h111);
      frame_pulse();
      step(); step();
      chk("same_next", 32'(pixel_out), 32'hF00);
      chk("same_pclr", 32'(cfg_pending_out), 0);

      // Blink on frame_count[0]: L1 over fill 0x0A0.
      cfg_write(4'b0010, 4'h0, 4'b0010, 12'h0A0);
      frame_pulse();
      set_layers(12'h000, 12'h00F, 12'h000, 12'h000, 4'b0010);
      for (int f = 0; f < 4; f++) begin
         step(); step(); step();
         chk("blink", 32'(pixel_out), fc_model[0] ? 32'h0A0 : 32'h00F);
         frame_pulse();
      end

      // Frame counter wrap.
      while (fc_model != 8'd255) frame_pulse();
      chk("fcnt_255", 32'(frame_count_out), 255);
      frame_pulse();
      chk("fcnt_wrap", 32'(frame_count_out), 0);

      // Asynchronous reset mid-frame.
      cfg_write(4'h1, 4'h0, 4'h0, 12'h777);
      set_layers(12'h321, 12'h654, 12'h987, 12'hCBA, 4'hF);
      step(); step();
      #2 rst_in = 1'b1;
      #1;
      chk("arst_pixel", 32'(pixel_out), 0);
      chk("arst_pend",  32'(cfg_pending_out), 0);
      step();
      rst_in = 1'b0; fc_model = '0;
      step(); step();
      chk("arst_default", 32'(pixel_out), 32'hCBA);
      chk("arst_fcnt", 32'(frame_count_out), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

endmodule

// File: doc/vga_layer_compositor.md
# vga_layer_compositor

Parametrised, pipelined pixel compositor that merges `NUM_LAYERS` RGB pixel sources into one VGA pixel. Each layer has its own enable, transparency, 50% blend and blink controls. It sits between the per-layer pixel generators (camera, channel/threshold views, game, sprites, crosshair) and the VGA output registers. All layer controls are shadowed and applied only at a frame boundary, so the picture never tears mid-frame. Sync and blank signals are delayed to match the pixel latency.

## Interface

Parameters:
- `NUM_LAYERS`, 4: number of input layers. Layer 0 is the bottom layer and highest index is the top. Legal range is 1..8.
- `PIXEL_WIDTH`, 12: total RGB bits. Must be divisible by 3; channel width is `CW = PIXEL_WIDTH/3`.
- `FRAME_CNT_WIDTH`, 8: width of the frame counter.
- `BLINK_BIT`, 4: frame-counter bit that gates blinking layers.

Ports:
- `clk_in` input 1: pixel clock.
- `rst_in` input 1: reset, asynchronous, active-high.
- `layer_pixel_in` input `NUM_LAYERS*PIXEL_WIDTH`: layer i occupies `[i*PIXEL_WIDTH +: PIXEL_WIDTH]`.
- `layer_opaque_in` input `NUM_LAYERS`: bit i=1 means layer i has a non-transparent pixel this cycle.
- `hsync_in`, `vsync_in`, `blank_in` input 1 each: timing signals aligned with the pixels. `vsync_in` is active-high.
- `cfg_write_in` input 1: one-cycle strobe that loads the shadow configuration.
- `cfg_enable_in` input `NUM_LAYERS`: layer enable.
- `cfg_blend_in` input `NUM_LAYERS`: 1 = 50% blend with the result below; 0 = replace.
- `cfg_blink_in` input `NUM_LAYERS`: 1 = layer is gated by the blink bit.
- `cfg_fill_in` input `PIXEL_WIDTH`: background colour used beneath layer 0.
- `pixel_out` output `PIXEL_WIDTH`: composited pixel.
- `hsync_out`, `vsync_out`, `blank_out` output 1 each: timing inputs delayed by 2 cycles.
- `frame_count_out` output `FRAME_CNT_WIDTH`: current frame number.
- `cfg_pending_out` output 1: shadow configuration is written but not yet applied.

## Operation

Configuration:
- `cfg_write_in`=1 copies all `cfg_*_in` inputs into the shadow registers and sets `cfg_pending_out`.
- A frame edge is `vsync_in & ~vsync_q`, where `vsync_q` is `vsync_in` registered and resets to 0.
- On a frame edge with pending=1: active ← shadow, and pending clears.
- If a write and a frame edge occur in the same cycle:
  - the write goes to shadow and pending stays 1;
  - active takes the old shadow value only if pending was already 1;
  - the new values apply at the next frame edge.
- The frame counter increments on every frame edge and wraps from max to 0.
- Reset values:
  - active and shadow enable = all ones;
  - blend = 0, blink = 0, fill = 0;
  - pending = 0;
  - frame counter = 0.

Stage 1 (registered):
- Captures the pixels and timing inputs.
- Computes `vis[i] = opaque[i] & enable_act[i] & ~(blink_act[i] & frame_count[BLINK_BIT])`.

Stage 2 (registered):
- Start with `acc = fill_act`.
- For i = 0 up to `NUM_LAYERS-1`, if `vis[i]`:
  - `acc = blend_act[i] ? avg(acc, pix[i]) : pix[i]`.
- `avg` is computed per channel as `({1'b0,a}+b)>>1`, i.e. `CW+1`-bit sum, truncated, with no rounding.
- `pixel_out = blank ? 0 : acc`.
- A layer with no visible pixel contributes nothing. With no visible layers, `pixel_out` = fill.

Active configuration is sampled by stage 1, so a change takes effect on the first pixel that enters after the frame edge.

## Timing

- Latency is exactly 2 cycles, from input sample to `pixel_out`/sync/blank outputs, with a throughput of 1 pixel per cycle.
- `hsync_out`, `vsync_out` and `blank_out` go through the same 2 register stages, so alignment is exact.
- `cfg_pending_out` is registered:
  - it rises the cycle after `cfg_write_in`;
  - it falls the cycle after the applying frame edge.
- `frame_count_out` updates the cycle after the frame edge.
- Reset values of all outputs are 0:
  - `pixel_out`, `hsync_out`, `vsync_out`, `blank_out`;
  - `frame_count_out`, `cfg_pending_out`.
- Asserting reset mid-frame immediately clears the pipeline, counter and configuration.
- If `vsync_in` is high when reset is released, the first clock counts as a frame edge.

## Test plan

- **Reset:** hold `rst_in` with random inputs -> all outputs 0. After release with all layers opaque and default config, `pixel_out` equals layer 3's pixel at cycle 2.
- **Priority:** L0=0x111 opaque, L2=0xF00 opaque, L3 transparent, L1 transparent -> `pixel_out`=0xF00 two cycles later. Make L2 transparent -> 0x111.
- **Blend:** L0=0x0F0 opaque, L1=0xF00 opaque with blend=1, others off -> 0x770. Blend 0xFFF over fill 0x000 -> 0x777.
- **Shadowing:**
  - Mid-frame, write enable=4'b1011 (L2 off) -> `cfg_pending_out`=1 and output still shows L2.
  - On the vsync rising edge, pending drops and L2 disappears.
  - Writing on the same cycle as the edge -> the change applies one frame later.
- **Blink:** `BLINK_BIT`=0, L1 blink on, L1=0x00F over fill 0x0A0 -> output alternates 0x00F/0x0A0 on successive frames. `frame_count_out` wraps 255->0.
- **Blank/sync:** `blank_in`=1 with visible layers -> `pixel_out`=0x000. A one-cycle hsync/vsync pulse appears exactly 2 cycles later on the outputs.
